prbs18_checker: RTL and testbench

Serial PRBS checker that sits directly downstream of the 18-bit Fibonacci LFSR. It consumes the generator's one-bit output stream, obeying s(n) = s(n-11) XOR s(n-18). It self-synchronises to that stream without knowing the seed, declares lock, then counts bit errors and compared bits for link or bench BER measurement.

---
 rtl/prbs18_pkg.sv | 14 +
 rtl/sat_counter.sv | 20 ++
 rtl/prbs18_checker.sv | 131 +++++++++++++
 tb/tb_prbs18_checker.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/prbs18_pkg.sv
// prbs18_pkg: shared constants and the state type for the PRBS-18 checker.
//   PRBS_LEN : LFSR length, which is also the history depth
//   TAP_A/B  : history taps that form the prediction s(n) = s(n-11) ^ s(n-18)
package prbs18_pkg;
  localparam int PRBS_LEN = 18;
  localparam int TAP_A    = 11;
  localparam int TAP_B    = 18;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    VERIFY  = 2'd1,
    LOCKED  = 2'd2
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clock : rising-edge clock
//   clear : synchronous active-high clear to zero
//   inc   : advance by one this edge (ignored once saturated)
//   count : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clock) begin
    if (clear)                     count <= '0;
    else if (inc && (count != '1)) count <= count + ONE;
  end
endmodule

// File: rtl/prbs18_checker.sv
// prbs18_checker: self-synchronising checker for the PRBS-18 stream
// s(n) = s(n-11) ^ s(n-18). It fills its history from the line, verifies
// LOCK_COUNT consecutive predictions, then free-runs its reference and counts
// mismatches and compared bits. LOSS_COUNT back-to-back mismatches drop lock.
//   clock     : rising-edge clock
//   clear     : synchronous active-high reset (priority over in_valid)
//   in_bit    : received stream bit
//   in_valid  : qualifies in_bit; nothing changes on edges where it is low
//   locked    : high while in LOCKED
//   err_flag  : one-cycle pulse per mismatch accepted in LOCKED
//   err_count : saturating mismatch count (LOCKED only)
//   bit_count : saturating compared-bit count (LOCKED only)
module prbs18_checker
  import prbs18_pkg::*;
#(
  parameter int LOCK_COUNT = 32,
  parameter int LOSS_COUNT = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);
  localparam logic [7:0] LOCK_C   = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_C   = 8'(LOSS_COUNT);
  localparam logic [4:0] FILL_END = 5'(PRBS_LEN - 1);

  state_t              r_state;
  logic [PRBS_LEN:1]   r_hist;
  logic [4:0]          r_fill;
  logic [7:0]          r_run;
  logic [7:0]          r_consec;
  logic                r_locked;
  logic                r_err_flag;

  logic                w_pred;
  logic                w_miss;
  logic                w_bit_inc;
  logic                w_err_inc;
  logic [7:0]          w_run_nxt;
  logic [7:0]          w_consec_nxt;

  assign w_pred       = r_hist[TAP_A] ^ r_hist[TAP_B];
  assign w_miss       = (in_bit != w_pred);
  assign w_run_nxt    = r_run + 8'd1;
  assign w_consec_nxt = r_consec + 8'd1;

  // Counters only advance on valid edges compared in LOCKED; clear wins.
  assign w_bit_inc = in_valid && (r_state == LOCKED);
  assign w_err_inc = w_bit_inc && w_miss;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state    <= ACQUIRE;
      r_hist     <= '0;
      r_fill     <= '0;
      r_run      <= '0;
      r_consec   <= '0;
      r_locked   <= 1'b0;
      r_err_flag <= 1'b0;
    end else begin
      r_err_flag <= 1'b0;
      if (in_valid) begin
        case (r_state)
          ACQUIRE: begin
            r_hist <= {r_hist[PRBS_LEN-1:1], in_bit};
            r_fill <= r_fill + 5'd1;
            if (r_fill == FILL_END) begin
              r_state <= VERIFY;
              r_run   <= '0;
            end
          end
          VERIFY: begin
            r_hist <= {r_hist[PRBS_LEN-1:1], in_bit};
            // All-zero history predicts zero forever; treating it as a miss
            // keeps a stuck-at-0 line from ever locking.
            if (!w_miss && (r_hist != '0)) begin
              if (w_run_nxt == LOCK_C) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_consec <= '0;
              end
              r_run <= w_run_nxt;
            end else begin
              r_run <= '0;
            end
          end
          LOCKED: begin
            // Reference free-runs on its own prediction so a single line
            // error is counted once instead of poisoning later predictions.
            r_hist <= {r_hist[PRBS_LEN-1:1], w_pred};
            if (w_miss) begin
              r_err_flag <= 1'b1;
              r_consec   <= w_consec_nxt;
              if (w_consec_nxt == LOSS_C) begin
                r_state  <= ACQUIRE;
                r_locked <= 1'b0;
                r_fill   <= '0;
              end
            end else begin
              r_consec <= '0;
            end
          end
          default: r_state <= ACQUIRE;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clock (clock),
    .clear (clear),
    .inc   (w_err_inc),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clock (clock),
    .clear (clear),
    .inc   (w_bit_inc),
    .count (bit_count)
  );

  assign locked   = r_locked;
  assign err_flag = r_err_flag;
endmodule

// File: tb/tb_prbs18_checker.sv
module tb_prbs18_checker;
  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        locked;
  logic        err_flag;
  logic [15:0] err_count;
  logic [15:0] bit_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic  lk;
    logic  fl;
  } exp_t;
  exp_t sb[$];

  logic [18:1] gh;  // reference LFSR history, gh[1] newest

  prbs18_checker #(.LOCK_COUNT(32), .LOSS_COUNT(8), .CNT_W(16)) dut (
    .clock     (clock),
    .clear     (clear),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .locked    (locked),
    .err_flag  (err_flag),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic gen(output logic b);
    b  = gh[11] ^ gh[18];
    gh = {gh[17:1], b};
  endtask

  // Drive one cycle; expectation goes to the scoreboard with the stimulus
  // and is retired once the registered outputs for that edge are visible.
  task automatic step(input logic v, input logic b, input logic elk, input logic efl,
                      input string tag);
    exp_t e;
    e.lk = elk;
    e.fl = efl;
    sb.push_back(e);
    in_valid = v;
    in_bit   = b;
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk({tag, ".locked"}, 32'(locked), 32'(e.lk));
    chk({tag, ".err_flag"}, 32'(err_flag), 32'(e.fl));
  endtask

  task automatic do_clear(input string tag);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clock);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk({tag, ".locked"}, 32'(locked), 0);
    chk({tag, ".err_flag"}, 32'(err_flag), 0);
    chk({tag, ".err_count"}, 32'(err_count), 0);
    chk({tag, ".bit_count"}, 32'(bit_count), 0);
  endtask

  initial begin
    logic b;
    int   nb;

    // 1) reset state, error-free lock over 10000 bits
    gh = 18'h1;
    do_clear("reset");
    for (int k = 1; k <= 10000; k++) begin
      gen(b);
      step(1'b1, b, (k >= 50), 1'b0, "clean");
    end
    chk("clean.err_count", 32'(err_count), 0);
    chk("clean.bit_count", 32'(bit_count), 9950);

    // 2) single inverted bit at bit 200
    gh = 18'h1;
    do_clear("clr_single");
    for (int k = 1; k <= 250; k++) begin
      gen(b);
      step(1'b1, (k == 200) ? ~b : b, (k >= 50), (k == 200), "single");
    end
    chk("single.err_count", 32'(err_count), 1);
    chk("single.bit_count", 32'(bit_count), 200);

    // 3) stuck-at-0 then stuck-at-1
    do_clear("clr_stuck0");
    for (int k = 1; k <= 500; k++) step(1'b1, 1'b0, 1'b0, 1'b0, "stuck0");
    chk("stuck0.err_count", 32'(err_count), 0);
    do_clear("clr_stuck1");
    for (int k = 1; k <= 500; k++) step(1'b1, 1'b1, 1'b0, 1'b0, "stuck1");
    chk("stuck1.err_count", 32'(err_count), 0);
    chk("stuck1.bit_count", 32'(bit_count), 0);

    // 4) 8-bit burst at 101..108 drops lock on 108, relock at 158
    gh = 18'h1;
    do_clear("clr_burst");
    for (int k = 1; k <= 200; k++) begin
      gen(b);
      step(1'b1, (k >= 101 && k <= 108) ? ~b : b,
           ((k >= 50 && k < 108) || k >= 158), (k >= 101 && k <= 108), "burst");
      if (k == 108) chk("burst.err_at_loss", 32'(err_count), 8);
    end
    chk("burst.err_count", 32'(err_count), 8);
    chk("burst.bit_count", 32'(bit_count), 100);

    // 5) in_valid every third cycle; junk on in_bit while invalid
    gh = 18'h1;
    do_clear("clr_gap");
    nb = 0;
    for (int c = 0; c < 30000; c++) begin
      if (c % 3 == 0) begin
        gen(b);
        nb++;
        step(1'b1, b, (nb >= 50), 1'b0, "gap");
      end else begin
        step(1'b0, 1'($urandom), (nb >= 50), 1'b0, "gap");
      end
    end
    chk("gap.err_count", 32'(err_count), 0);
    chk("gap.bit_count", 32'(bit_count), 9950);

    // 6) clear at bit 300 while locked with 3 errors, then relock
    gh = 18'h1;
    do_clear("clr_mid");
    for (int k = 1; k <= 299; k++) begin
      gen(b);
      step(1'b1, (k == 100 || k == 150 || k == 200) ? ~b : b, (k >= 50),
           (k == 100 || k == 150 || k == 200), "mid");
    end
    chk("mid.err_before", 32'(err_count), 3);
    do_clear("mid_clear");
    for (int j = 1; j <= 60; j++) begin
      gen(b);
      step(1'b1, b, (j >= 50), 1'b0, "relock");
    end
    chk("relock.err_count", 32'(err_count), 0);
    chk("relock.bit_count", 32'(bit_count), 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
